// File: rtl/riscv_bp_gshare.sv
// Correlating branch predictor: table of saturating counters indexed by PC and a
// speculative global history (concatenated or gshare XOR), cleared by a post-reset sweep.
module riscv_bp_gshare #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] PC_INIT    = 'h200,
    parameter int unsigned     GHR_BITS   = 8,
    parameter int unsigned     IDX_BITS   = 10,
    parameter int unsigned     IDX_LSB    = 2,
    parameter int unsigned     CNT_BITS   = 2,
    parameter int unsigned     INDEX_MODE = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_stall_i,
    input  logic [XLEN-1:0]     if_parcel_pc_i,
    input  logic                id_branch_i,
    output logic [CNT_BITS-1:0] bp_predict_o,
    output logic                bp_taken_o,
    output logic [GHR_BITS-1:0] bp_history_o,
    output logic                bp_ready_o,
    input  logic [XLEN-1:0]     ex_pc_i,
    input  logic [GHR_BITS-1:0] bu_bp_history_i,
    input  logic [CNT_BITS-1:0] bu_bp_predict_i,
    input  logic                bu_bp_btaken_i,
    input  logic                bu_bp_update_i,
    input  logic                bu_bp_mispredict_i
);
    localparam int unsigned TAB_BITS = (INDEX_MODE == 0) ? GHR_BITS + IDX_BITS : IDX_BITS;
    localparam logic [CNT_BITS-1:0] INIT_CNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [TAB_BITS-1:0] LAST_IDX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [TAB_BITS-1:0] sweep_q, sweep_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [XLEN-1:0]     pc_dly_q;
    logic [CNT_BITS-1:0] predict_q;
    logic [GHR_BITS-1:0] history_q;
    logic                ready_q;

    logic [CNT_BITS-1:0] cnt_tab [2**TAB_BITS];
    logic                tab_we;
    logic [TAB_BITS-1:0] tab_widx;
    logic [CNT_BITS-1:0] tab_wdata;

    logic [XLEN-1:0]     pc_sel;
    logic [TAB_BITS-1:0] rd_idx, wr_idx;

    function automatic logic [TAB_BITS-1:0] idx_of(input logic [XLEN-1:0] pc,
                                                    input logic [GHR_BITS-1:0] h);
        logic [IDX_BITS-1:0] pc_bits;
        pc_bits = pc[IDX_LSB +: IDX_BITS];
        if (INDEX_MODE == 0) return TAB_BITS'({h, pc_bits});
        else                 return TAB_BITS'(pc_bits ^ IDX_BITS'(h));
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_next(input logic [CNT_BITS-1:0] c,
                                                      input logic t);
        if (t) return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
        else   return (c == '0)      ? c : c - CNT_BITS'(1);
    endfunction

    // Truncating {h, b} keeps {h[GHR_BITS-2:0], b}, and just b when GHR_BITS == 1.
    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                      input logic b);
        return GHR_BITS'({h, b});
    endfunction

    assign pc_sel = id_stall_i ? pc_dly_q : if_parcel_pc_i;
    assign rd_idx = idx_of(pc_sel, ghr_q);
    assign wr_idx = idx_of(ex_pc_i, bu_bp_history_i);

    // Next-state: init sweep, training writes and GHR repair/speculation.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        ghr_d     = ghr_q;
        tab_we    = 1'b0;
        tab_widx  = sweep_q;
        tab_wdata = INIT_CNT;
        case (state_q)
            ST_INIT: begin
                tab_we  = 1'b1;
                sweep_d = sweep_q + TAB_BITS'(1);
                if (sweep_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bu_bp_update_i) begin
                    tab_we    = 1'b1;
                    tab_widx  = wr_idx;
                    tab_wdata = sat_next(bu_bp_predict_i, bu_bp_btaken_i);
                end
                if (bu_bp_update_i && bu_bp_mispredict_i)
                    ghr_d = shift_in(bu_bp_history_i, bu_bp_btaken_i);
                else if (id_branch_i && !id_stall_i)
                    ghr_d = shift_in(ghr_q, bp_taken_o);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            ghr_q     <= '0;
            pc_dly_q  <= PC_INIT;
            predict_q <= INIT_CNT;
            history_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
            ready_q <= (state_d == ST_RUN);
            if (!id_stall_i) pc_dly_q <= if_parcel_pc_i;
            if (state_q == ST_RUN) begin
                predict_q <= cnt_tab[rd_idx];
                history_q <= ghr_q;
            end else begin
                predict_q <= INIT_CNT;
                history_q <= '0;
            end
        end
    end

    // Table write port; a same-edge read above still sees the old entry.
    always_ff @(posedge clk_i) begin
        if (tab_we && !rst_i) cnt_tab[tab_widx] <= tab_wdata;
    end

    assign bp_predict_o = predict_q;
    assign bp_taken_o   = predict_q[CNT_BITS-1];
    assign bp_history_o = history_q;
    assign bp_ready_o   = ready_q;

    logic unused_ok;
    assign unused_ok = ^{if_parcel_pc_i, ex_pc_i, bu_bp_history_i};
endmodule

// File: tb/tb_riscv_bp_gshare.sv
// Bench for riscv_bp_gshare: a concat-indexed and a gshare-indexed instance share
// stimulus and are checked every cycle against a table-level model plus literal cases.
`timescale 1ns/1ps
module tb_riscv_bp_gshare;
    localparam int XLEN = 32;
    localparam int GB   = 3;
    localparam int IB   = 4;
    localparam int CB   = 3;
    localparam int NI   = 2;
    localparam int unsigned INITC = 3;
    localparam int unsigned CMAX  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_stall;
    logic [XLEN-1:0] if_pc;
    logic            id_branch;
    logic [XLEN-1:0] ex_pc;
    logic [GB-1:0]   bu_hist;
    logic [CB-1:0]   bu_pred;
    logic            bu_bt, bu_upd, bu_mis;

    logic [CB-1:0]   dut_pred  [NI];
    logic            dut_taken [NI];
    logic [GB-1:0]   dut_hist  [NI];
    logic            dut_ready [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_bp_gshare #(.XLEN(XLEN), .PC_INIT(32'h200), .GHR_BITS(GB), .IDX_BITS(IB),
                      .IDX_LSB(2), .CNT_BITS(CB), .INDEX_MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .id_stall_i(id_stall), .if_parcel_pc_i(if_pc),
        .id_branch_i(id_branch), .bp_predict_o(dut_pred[0]), .bp_taken_o(dut_taken[0]),
        .bp_history_o(dut_hist[0]), .bp_ready_o(dut_ready[0]), .ex_pc_i(ex_pc),
        .bu_bp_history_i(bu_hist), .bu_bp_predict_i(bu_pred), .bu_bp_btaken_i(bu_bt),
        .bu_bp_update_i(bu_upd), .bu_bp_mispredict_i(bu_mis));

    riscv_bp_gshare #(.XLEN(XLEN), .PC_INIT(32'h200), .GHR_BITS(GB), .IDX_BITS(IB),
                      .IDX_LSB(2), .CNT_BITS(CB), .INDEX_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_stall_i(id_stall), .if_parcel_pc_i(if_pc),
        .id_branch_i(id_branch), .bp_predict_o(dut_pred[1]), .bp_taken_o(dut_taken[1]),
        .bp_history_o(dut_hist[1]), .bp_ready_o(dut_ready[1]), .ex_pc_i(ex_pc),
        .bu_bp_history_i(bu_hist), .bu_bp_predict_i(bu_pred), .bu_bp_btaken_i(bu_bt),
        .bu_bp_update_i(bu_upd), .bu_bp_mispredict_i(bu_mis));

    // ---------------- behavioural model ----------------
    int unsigned mtab [NI][128];
    int unsigned mghr [NI];
    int unsigned mpred[NI];
    int unsigned mhist[NI];
    int unsigned mcnt [NI];
    bit          mready[NI];
    int unsigned mpc_dly;
    bit          mvalid = 1'b0;
    int unsigned m_psel, m_c, m_oldt;

    function automatic int unsigned depth_of(input int k);
        return (k == 0) ? (1 << (GB + IB)) : (1 << IB);
    endfunction

    function automatic int unsigned midx(input int k, input int unsigned pc, input int unsigned h);
        int unsigned b;
        b = (pc >> 2) % (1 << IB);
        if (k == 0) return h * (1 << IB) + b;
        return b ^ h;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mvalid  = 1'b1;
            mpc_dly = 32'h200;
            for (int k = 0; k < NI; k++) begin
                for (int e = 0; e < 128; e++) mtab[k][e] = INITC;
                mghr[k] = 0; mpred[k] = INITC; mhist[k] = 0; mcnt[k] = 0; mready[k] = 1'b0;
            end
        end else begin
            m_psel = id_stall ? mpc_dly : if_pc;
            for (int k = 0; k < NI; k++) begin
                m_oldt = (mpred[k] >> (CB - 1)) & 1;
                if (mcnt[k] >= depth_of(k)) begin
                    mpred[k] = mtab[k][midx(k, m_psel, mghr[k])];
                    mhist[k] = mghr[k];
                    if (bu_upd) begin
                        m_c = bu_pred;
                        mtab[k][midx(k, ex_pc, bu_hist)] =
                            bu_bt ? ((m_c < CMAX) ? m_c + 1 : m_c) : ((m_c > 0) ? m_c - 1 : 0);
                    end
                    if (bu_upd && bu_mis)
                        mghr[k] = (bu_hist * 2 + bu_bt) % (1 << GB);
                    else if (id_branch && !id_stall)
                        mghr[k] = (mghr[k] * 2 + m_oldt) % (1 << GB);
                end else begin
                    mpred[k] = INITC;
                    mhist[k] = 0;
                end
                if (mcnt[k] < depth_of(k)) mcnt[k]++;
                mready[k] = (mcnt[k] >= depth_of(k));
            end
            if (!id_stall) mpc_dly = if_pc;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mvalid) begin
            for (int k = 0; k < NI; k++) begin
                check("model_predict", k, dut_pred[k],  mpred[k]);
                check("model_taken",   k, dut_taken[k], (mpred[k] >> (CB - 1)) & 1);
                check("model_history", k, dut_hist[k],  mhist[k]);
                check("model_ready",   k, dut_ready[k], mready[k]);
            end
        end
    endtask

    task automatic idle();
        id_stall = 0; id_branch = 0; bu_upd = 0; bu_mis = 0; bu_bt = 0;
    endtask

    task automatic train(input int unsigned pc, input int unsigned h, input int unsigned p, input bit t);
        ex_pc = pc; bu_hist = GB'(h); bu_pred = CB'(p); bu_bt = t; bu_upd = 1;
        tick();
        bu_upd = 0;
    endtask

    // Deassert reset and count edges until each instance reports ready.
    task automatic sweep_count(output int n0, output int n1);
        int n;
        n = 0; n0 = 0; n1 = 0;
        rst = 0;
        while ((n0 == 0 || n1 == 0) && n < 400) begin
            tick();
            n++;
            if (dut_ready[0] && n0 == 0) n0 = n;
            if (dut_ready[1] && n1 == 0) n1 = n;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0, n1, cur;
        rst = 1; idle(); if_pc = 32'h200; ex_pc = 32'h200; bu_hist = '0; bu_pred = '0;
        repeat (2) tick();
        check("reset_predict", 0, dut_pred[0], 3);
        check("reset_taken",   0, dut_taken[0], 0);
        check("reset_history", 1, dut_hist[1], 0);
        check("reset_ready",   1, dut_ready[1], 0);

        sweep_count(n0, n1);
        check("sweep_cycles", 0, n0, 128);
        check("sweep_cycles", 1, n1, 16);

        // gshare aliasing: PC 0x20C with history 3 trains entry 0, read back by PC 0x200, history 0
        train(32'h20C, 3, 3, 1);
        train(32'h20C, 3, 4, 1);
        if_pc = 32'h200;
        tick();
        check("alias_predict", 1, dut_pred[1], 5);
        check("alias_taken",   1, dut_taken[1], 1);
        check("noalias_predict", 0, dut_pred[0], 3);

        // saturation up then down on PC 0x240
        if_pc = 32'h240;
        tick();
        for (int i = 0; i < 6; i++) begin
            cur = (3 + i > 7) ? 7 : 3 + i;
            check("sat_up", 0, dut_pred[0], cur);
            if (i < 5) begin train(32'h240, 0, cur, 1); tick(); end
        end
        for (int j = 0; j < 8; j++) begin
            train(32'h240, 0, (7 - j > 0) ? 7 - j : 0, 0);
            tick();
            check("sat_down", 0, dut_pred[0], (6 - j > 0) ? 6 - j : 0);
        end

        // speculative history: predictions T, N, T build 0b101
        train(32'h204, 0, 6, 1);
        train(32'h20C, 2, 6, 1);
        if_pc = 32'h204; tick();
        check("ghr_pred_T1", 0, dut_taken[0], 1);
        id_branch = 1; tick();
        id_branch = 0; if_pc = 32'h208; tick();
        check("ghr_pred_N", 0, dut_taken[0], 0);
        id_branch = 1; tick();
        id_branch = 0; if_pc = 32'h20C; tick();
        check("ghr_pred_T2", 0, dut_taken[0], 1);
        id_branch = 1; tick();
        id_branch = 0; tick();
        check("ghr_after_TNT", 0, dut_hist[0], 5);

        // repair beats a same-cycle speculative shift
        id_branch = 1; bu_upd = 1; bu_mis = 1; bu_hist = 3'b100; bu_bt = 1; bu_pred = 3;
        ex_pc = 32'h210; tick();
        idle(); tick();
        check("ghr_repair", 0, dut_hist[0], 1);
        check("ghr_repair", 1, dut_hist[1], 1);

        // stall holds the read PC
        if_pc = 32'h204; tick();
        check("pre_stall", 0, dut_pred[0], 3);
        id_stall = 1;
        for (int i = 0; i < 4; i++) begin
            if_pc = $urandom;
            tick();
            check("stall_hold", 0, dut_pred[0], 3);
        end
        id_stall = 0;

        // collision: write and read the same entry in one cycle
        if_pc = 32'h204;
        train(32'h204, 1, 3, 1);
        check("collide_old", 0, dut_pred[0], 3);
        tick();
        check("collide_new", 0, dut_pred[0], 4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 699) == 0);
            id_stall  = ($urandom_range(0, 3) == 0);
            id_branch = ($urandom_range(0, 2) == 0);
            if_pc     = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : 32'h200 + ($urandom_range(0, 15) << 2);
            ex_pc     = 32'h200 + ($urandom_range(0, 15) << 2);
            bu_hist   = GB'($urandom);
            bu_pred   = CB'($urandom);
            bu_bt     = $urandom_range(0, 1);
            bu_upd    = $urandom_range(0, 1);
            bu_mis    = ($urandom_range(0, 3) == 0);
            tick();
        end

        // reset partway through a sweep restarts it from entry 0
        idle(); rst = 1; tick();
        rst = 0;
        repeat (100) tick();
        check("midsweep_not_ready", 0, dut_ready[0], 0);
        rst = 1; tick();
        sweep_count(n0, n1);
        check("resweep_cycles", 0, n0, 128);
        check("resweep_cycles", 1, n1, 16);
        for (int p = 0; p < 16; p++) begin
            if_pc = 32'h200 + p * 4;
            tick();
            check("resweep_init", 0, dut_pred[0], 3);
            check("resweep_init", 1, dut_pred[1], 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
